// File: rtl/syscall_unit_pkg.sv
// Shared constants for the syscall unit: state encoding, service codes, default widths.
package syscall_unit_pkg;

  localparam int unsigned CTRL_ALU_OP_WIDTH = 4;
  localparam int unsigned CTRL_REG_SEL_WIDTH = 5;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF = 32;

  localparam int unsigned SYS_ST_WIDTH = 2;
  localparam logic [SYS_ST_WIDTH-1:0] SYS_ST_RUN = 2'd0;
  localparam logic [SYS_ST_WIDTH-1:0] SYS_ST_PAUSED = 2'd1;
  localparam logic [SYS_ST_WIDTH-1:0] SYS_ST_HALTED = 2'd2;

  localparam int unsigned V0_PRINT_DEF = 34;
  localparam int unsigned V0_HALT_DEF = 10;
  localparam int unsigned V0_PAUSE_DEF = 50;

  typedef enum logic [SYS_ST_WIDTH-1:0] {
    StRun    = SYS_ST_RUN,
    StPaused = SYS_ST_PAUSED,
    StHalted = SYS_ST_HALTED
  } sys_state_e;

endpackage

// File: rtl/syscall_unit_if.sv
// Request/status bundle between the execute stage (master) and the syscall unit (slave).
interface syscall_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  en;
  logic                  syscall_en;
  logic [DATA_WIDTH-1:0] reg_v0;
  logic [DATA_WIDTH-1:0] reg_a0;
  logic                  resume;
  logic                  stall_req;
  logic                  halt;
  logic [DATA_WIDTH-1:0] display_data;
  logic                  display_valid;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [CNT_WIDTH-1:0]  syscall_count;
  logic                  err;

  modport master (
    output en, syscall_en, reg_v0, reg_a0, resume,
    input  stall_req, halt, display_data, display_valid, cycle_count, syscall_count, err
  );

  modport slave (
    input  en, syscall_en, reg_v0, reg_a0, resume,
    output stall_req, halt, display_data, display_valid, cycle_count, syscall_count, err
  );
endinterface

// File: rtl/syscall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear_i is synchronous.
module syscall_unit_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/syscall_unit.sv
// Execute-stage syscall handler: print / halt / pause services, stall/halt control, counters.
// Define SYSCALL_UNKNOWN_TRAP_EN to halt with err on unrecognised service codes.
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned V0_PRINT   = V0_PRINT_DEF,
  parameter int unsigned V0_HALT    = V0_HALT_DEF,
  parameter int unsigned V0_PAUSE   = V0_PAUSE_DEF
) (
  input logic           clk,
  input logic           rst,
  syscall_unit_if.slave bus
);

  sys_state_e            state_d, state_q;
  logic [DATA_WIDTH-1:0] display_d, display_q;
  logic                  valid_d, valid_q;
  logic                  stall_d, stall_q;
  logic                  halt_d, halt_q;
  logic                  err_d, err_q;
  logic                  accept;
  logic                  in_run;

  assign in_run = (state_q == StRun);
  // A held stage (en=0) leaves the syscall presented; it is taken once en rises.
  assign accept = in_run && bus.en && bus.syscall_en;

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (bus.reg_v0 == DATA_WIDTH'(V0_PRINT)) begin
            display_d = bus.reg_a0;
            valid_d   = 1'b1;
          end else if (bus.reg_v0 == DATA_WIDTH'(V0_HALT)) begin
            state_d = StHalted;
          end else if (bus.reg_v0 == DATA_WIDTH'(V0_PAUSE)) begin
            state_d = StPaused;
          end else begin
`ifdef SYSCALL_UNKNOWN_TRAP_EN
            state_d = StHalted;
            err_d   = 1'b1;
`endif
          end
        end
      end
      StPaused: begin
        if (bus.resume) begin
          state_d = StRun;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
    stall_d = (state_d != StRun);
    halt_d  = (state_d == StHalted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      display_q <= '0;
      valid_q   <= 1'b0;
      stall_q   <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      valid_q   <= valid_d;
      stall_q   <= stall_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
    end
  end

  syscall_unit_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (in_run),
    .count_o (bus.cycle_count)
  );

  syscall_unit_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_syscall_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (accept),
    .count_o (bus.syscall_count)
  );

  assign bus.display_data  = display_q;
  assign bus.display_valid = valid_q;
  assign bus.stall_req     = stall_q;
  assign bus.halt          = halt_q;
`ifdef SYSCALL_UNKNOWN_TRAP_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
